// File: rtl/pixel_seq_pkg.sv
`default_nettype none
// pixel_seq_pkg: state encoding, default sizes and index-width helper shared by
// the pixel_array_sequencer slice (rev 1.0).
package pixel_seq_pkg;

  localparam int NPIX_DEFAULT = 9;
  localparam int TO_W_DEFAULT = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  // The index must be able to hold NPIX itself, which marks the end of a scan.
  function automatic int idx_width(input int npix);
    return $clog2(npix + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_seq_timer.sv
`default_nettype none
// pixel_seq_timer: loadable, saturating wait counter; expired flags the last
// allowed cycle of a wait when a non-zero limit is loaded (rev 1.0).
module pixel_seq_timer
  import pixel_seq_pkg::*;
#(
  parameter int TO_W = TO_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [TO_W-1:0] limit,
  input  logic            clear,
  input  logic            enable,
  output logic            expired
);

  logic [TO_W-1:0] count;
  logic [TO_W-1:0] limit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      limit_q <= '0;
    end else begin
      if (load) begin
        limit_q <= limit;
      end
      if (clear || load) begin
        count <= '0;
      end else if (enable && (count != '1)) begin
        count <= count + TO_W'(1);
      end
    end
  end

  assign expired = (limit_q != '0) && (count == limit_q - TO_W'(1));

endmodule
`default_nettype wire

// File: rtl/pixel_array_sequencer.sv
`default_nettype none
// pixel_array_sequencer: scans enabled pixel FSMs in index order, one start at a
// time; timeout/error logic exists only with PIXEL_SEQ_TIMEOUT_EN (rev 1.0).
module pixel_array_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int NPIX  = NPIX_DEFAULT,
  parameter int TO_W  = TO_W_DEFAULT,
  parameter int IDX_W = idx_width(NPIX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [NPIX-1:0]  pxl_mask_i,
  input  logic [TO_W-1:0]  timeout_i,
  input  logic [NPIX-1:0]  pxl_done_i,
  output logic [NPIX-1:0]  pxl_start_o,
  output logic [IDX_W-1:0] pxl_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [NPIX-1:0]  err_mask_o
);

  seq_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [NPIX-1:0]  mask, mask_nxt;
  logic [NPIX-1:0]  sel_onehot;
  logic             mask_bit, done_bit;
  logic             accept, tmr_clear, tmr_run, timed_out, expired;

  // Shifting out past NPIX yields zero, so idx == NPIX selects no pixel.
  assign sel_onehot = NPIX'(1) << idx;
  assign mask_bit   = |(mask & sel_onehot);
  assign done_bit   = |(pxl_done_i & sel_onehot);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    mask_nxt  = mask;
    accept    = 1'b0;
    tmr_clear = 1'b0;
    tmr_run   = 1'b0;
    timed_out = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          accept    = 1'b1;
          mask_nxt  = pxl_mask_i;
          idx_nxt   = '0;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (idx == IDX_W'(NPIX)) begin
          state_nxt = ST_DONE;
        end else if (!mask_bit) begin
          idx_nxt = idx + IDX_W'(1);
        end else begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        tmr_clear = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Done is checked first so a same-cycle expiry never flags an error.
        if (done_bit) begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = ST_SCAN;
        end else if (expired) begin
          timed_out = 1'b1;
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = ST_SCAN;
        end else begin
          tmr_run = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      mask        <= '0;
      pxl_start_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      mask        <= mask_nxt;
      pxl_start_o <= (state == ST_START) ? sel_onehot : '0;
      done_o      <= (state == ST_DONE);
      // Held through the cycle done_o is shown so both drop together.
      busy_o      <= (state_nxt != ST_IDLE) || (state == ST_DONE);
    end
  end

  assign pxl_idx_o = idx;

`ifdef PIXEL_SEQ_TIMEOUT_EN
  logic [NPIX-1:0] err_mask;

  pixel_seq_timer #(.TO_W(TO_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .limit   (timeout_i),
    .clear   (tmr_clear),
    .enable  (tmr_run),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      err_mask <= '0;
      err_o    <= 1'b0;
    end else if (timed_out) begin
      err_mask <= err_mask | sel_onehot;
      err_o    <= 1'b1;
    end
  end

  assign err_mask_o = err_mask;
`else
  logic unused_ctl;

  assign expired    = 1'b0;
  assign err_mask_o = '0;
  assign err_o      = 1'b0;
  assign unused_ctl = ^{timeout_i, accept, tmr_clear, tmr_run, timed_out};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_array_sequencer.sv
`default_nettype none
// tb_pixel_array_sequencer: directed and random scans scored against a
// cycle-arithmetic reference model through start/done queues.
module tb_pixel_array_sequencer;

  localparam int NPIX  = 9;
  localparam int TO_W  = 12;
  localparam int IDX_W = $clog2(NPIX + 1);
  localparam int NEVER = 1000000;
`ifdef PIXEL_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic [NPIX-1:0]  pxl_mask_i = '0;
  logic [TO_W-1:0]  timeout_i = '0;
  logic [NPIX-1:0]  pxl_done_i = '0;
  logic [NPIX-1:0]  pxl_start_o;
  logic [IDX_W-1:0] pxl_idx_o;
  logic             busy_o, done_o, err_o;
  logic [NPIX-1:0]  err_mask_o;

  pixel_array_sequencer #(.NPIX(NPIX), .TO_W(TO_W), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .pxl_mask_i (pxl_mask_i),
    .timeout_i  (timeout_i),
    .pxl_done_i (pxl_done_i),
    .pxl_start_o(pxl_start_o),
    .pxl_idx_o  (pxl_idx_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_mask_o (err_mask_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  typedef struct { int idx; int cyc; } start_exp_t;
  typedef struct { logic [NPIX-1:0] err; int cyc; } done_exp_t;
  start_exp_t exp_start[$];
  done_exp_t  exp_done[$];

  // Per-pixel response delay in cycles after the start pulse is seen.
  int pd  [NPIX];
  int rem [NPIX];

  always @(negedge clk) begin
    for (int p = 0; p < NPIX; p++) begin
      if (rst) begin
        rem[p] = 0;
        pxl_done_i[p] = 1'b0;
      end else if (pxl_start_o[p]) begin
        rem[p] = pd[p];
        pxl_done_i[p] = (pd[p] == 0);
      end else if (rem[p] > 0) begin
        rem[p]--;
        if (rem[p] == 0) pxl_done_i[p] = 1'b1;
      end
    end
  end

  // Reference: b is the edge that samples start_i; every SCAN step costs one
  // cycle, a start is visible 2 edges after its SCAN step, and the wait ends
  // on done (delay+1 edges later) or on expiry (tmo edges later).
  task automatic model_scan(input int b, input logic [NPIX-1:0] m, input int tmo);
    int t;
    int p;
    logic [NPIX-1:0] err;
    t = 0;
    err = '0;
    for (int i = 0; i < NPIX; i++) begin
      if (!m[i]) begin
        t++;
      end else begin
        p = t + 2;
        exp_start.push_back('{i, b + p});
        if (TO_EN && tmo != 0 && tmo <= pd[i]) begin
          err[i] = 1'b1;
          t = p + tmo;
        end else begin
          t = p + 1 + pd[i];
        end
      end
    end
    exp_done.push_back('{err, b + t + 2});
  endtask

  always @(negedge clk) begin : monitor
    start_exp_t se;
    done_exp_t  de;
    bit         prev_done;
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        check("done_one_cycle", {31'd0, done_o}, 0);
        check("busy_falls_with_done", {31'd0, busy_o}, 0);
      end
      prev_done = done_o;
      if (pxl_start_o != '0) begin
        if (exp_start.size() == 0) begin
          check("unexpected_start", {23'd0, pxl_start_o}, 0);
        end else begin
          se = exp_start.pop_front();
          check("start_onehot", {23'd0, pxl_start_o}, 32'd1 << se.idx);
          check("start_cycle", cyc, se.cyc);
          check("start_idx", {28'd0, pxl_idx_o}, se.idx);
          check("busy_during_start", {31'd0, busy_o}, 1);
        end
      end
      if (done_o) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", {31'd0, done_o}, 0);
        end else begin
          de = exp_done.pop_front();
          check("done_cycle", cyc, de.cyc);
          check("err_mask", {23'd0, err_mask_o}, {23'd0, de.err});
          check("err_o", {31'd0, err_o}, {31'd0, |de.err});
          check("busy_at_done", {31'd0, busy_o}, 1);
        end
      end
    end
  end

  task automatic start_scan(input logic [NPIX-1:0] m, input int tmo, input bit poke);
    int w;
    @(negedge clk);
    w = 0;
    while (busy_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("idle_before_start", {31'd0, busy_o}, 0);
    start_i    = 1'b1;
    pxl_mask_i = m;
    timeout_i  = TO_W'(tmo);
    model_scan(cyc + 1, m, tmo);
    @(negedge clk);
    start_i = 1'b0;
    if (poke) begin
      // A request mid-scan must be dropped and the latched settings kept.
      repeat (3) @(negedge clk);
      start_i    = 1'b1;
      pxl_mask_i = NPIX'($urandom);
      timeout_i  = TO_W'($urandom);
      @(negedge clk);
      start_i = 1'b0;
    end
  endtask

  task automatic run_scan(input logic [NPIX-1:0] m, input int tmo, input bit poke);
    int w;
    start_scan(m, tmo, poke);
    w = 0;
    while ((exp_start.size() != 0 || exp_done.size() != 0) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("scan_drained", exp_start.size() + exp_done.size(), 0);
    exp_start.delete();
    exp_done.delete();
  endtask

  task automatic set_delays(input int d);
    for (int p = 0; p < NPIX; p++) pd[p] = d;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w;
    logic [NPIX-1:0] m;
    int tmo;
    set_delays(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_pxl_start", {23'd0, pxl_start_o}, 0);
    check("rst_pxl_idx", {28'd0, pxl_idx_o}, 0);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_done", {31'd0, done_o}, 0);
    check("rst_err", {31'd0, err_o}, 0);
    check("rst_err_mask", {23'd0, err_mask_o}, 0);

    set_delays(3);
    run_scan(9'h1FF, 0, 1'b0);

    for (int p = 0; p < NPIX; p++) pd[p] = $urandom_range(0, 4);
    run_scan(9'h105, 0, 1'b0);

    set_delays(0);
    pd[4] = TO_EN ? NEVER : 6;
    run_scan(9'h1FF, 5, 1'b0);

    set_delays(0);
    pd[2] = 3;
    pd[6] = 4;
    run_scan(9'h1FF, 4, 1'b0);

    run_scan(9'h000, 0, 1'b1);

    // Reset while waiting on pixel 3, after pixel 1 may already have errored.
    set_delays(1);
    pd[1] = TO_EN ? NEVER : 1;
    pd[3] = NEVER;
    start_scan(9'h1FF, 3, 1'b0);
    w = 0;
    while (!pxl_start_o[3] && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("reached_pixel3", {31'd0, pxl_start_o[3]}, 1);
    check("err_before_reset", {31'd0, err_o}, {31'd0, TO_EN});
    #1;
    rst = 1'b1;
    exp_start.delete();
    exp_done.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy_o}, 0);
    check("midrst_idx", {28'd0, pxl_idx_o}, 0);
    check("midrst_err", {31'd0, err_o}, 0);
    check("midrst_err_mask", {23'd0, err_mask_o}, 0);
    set_delays(2);
    run_scan(9'h1FF, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      m   = NPIX'($urandom);
      tmo = $urandom_range(0, 8);
      for (int p = 0; p < NPIX; p++) begin
        pd[p] = $urandom_range(0, 10);
        if (TO_EN && tmo != 0 && $urandom_range(0, 4) == 0) pd[p] = NEVER;
      end
      run_scan(m, tmo, (k % 3) == 0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_array_sequencer.md
# pixel_array_sequencer

Sequences a bank of `NPIX` pixel FSMs that together form one kernel. A single `start_i` pulse scans the pixels in ascending index order, skipping masked ones. For each enabled pixel it issues a one-cycle start, then waits for that pixel's done or for a timeout. It reports per-pixel timeout errors and pulses `done_o` when the scan completes. It sits between the Wishbone control register and the pixel FSM instances, replacing a direct software-driven start bit.

## Interface
- `NPIX`, default 9: number of pixel FSMs sequenced; must be ≥ 1.
- `TO_W`, default 12: width of the timeout counter and the timeout limit.
- `IDX_W`, default `$clog2(NPIX+1)`: width of the index counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  scan request; sampled only in IDLE.
- `pxl_mask_i`  in  NPIX  enabled pixels; 1 = enabled. Latched at scan start.
- `timeout_i`  in  TO_W  wait limit in cycles; 0 = no timeout. Latched at scan start.
- `pxl_done_i`  in  NPIX  per-pixel done level from the pixel FSMs.
- `pxl_start_o`  out  NPIX  one-hot start pulse to a pixel FSM.
- `pxl_idx_o`  out  IDX_W  index currently being serviced.
- `busy_o`  out  1  high from scan accept until DONE exits.
- `done_o`  out  1  one-cycle pulse at scan end.
- `err_o`  out  1  high if any pixel timed out in the last scan.
- `err_mask_o`  out  NPIX  per-pixel timeout flags from the last scan.

## Operation
- States: IDLE, SCAN, START, WAIT, DONE.
- IDLE:
  - On `start_i`: latch mask and timeout, set idx = 0, clear `err_mask_o`, go to SCAN.
  - `start_i` outside IDLE is ignored; it is not queued.
- SCAN:
  - idx == NPIX → DONE.
  - Else if mask[idx] == 0 → idx+1, stay in SCAN.
  - Else → START.
- START:
  - `pxl_start_o[idx]` = 1 for exactly this cycle.
  - Clear the timer, go to WAIT.
- WAIT, evaluated each cycle:
  - `pxl_done_i[idx]` high → idx+1, SCAN.
  - Else, if timeout ≠ 0 and timer == timeout−1 → set `err_mask_o[idx]`, idx+1, SCAN.
  - Else timer+1.
  - If done and the timeout expire in the same cycle, done wins and no error is set.
  - `pxl_done_i` of non-selected pixels is ignored.
- DONE: `done_o` = 1 for one cycle, then go to IDLE.
- Width rules:
  - idx counts 0..NPIX inclusive.
  - The timer saturates at its maximum; it never wraps.
- `err_o` = OR of `err_mask_o`. It holds until the next accepted `start_i` or `rst`.
- An all-zero mask is legal: IDLE → SCAN (NPIX cycles) → DONE, with no starts issued.
- `rst` mid-scan: immediate return to IDLE and all outputs cleared. No start is reissued.

## Timing
- Reset values:
  - `pxl_start_o` = 0, `pxl_idx_o` = 0, `busy_o` = 0, `done_o` = 0.
  - `err_o` = 0, `err_mask_o` = 0.
  - Timer = 0, state = IDLE.
- All outputs are registered.
- Scan start: `start_i` sampled high at edge 0 → `busy_o` = 1 after edge 0. If pixel 0 is enabled, `pxl_start_o[0]` is high after edge 2.
- Done-to-next-start: a done observed at edge k → the next enabled pixel `j` gets its start after edge k+2+(skipped count).
- Timeout T: the error is set T cycles after START with no done.
- `busy_o` falls on the same edge that `done_o` falls.

## Configuration
- `PIXEL_SEQ_TIMEOUT_EN` defined: timer, `timeout_i` and error logic are present as described above.
- `PIXEL_SEQ_TIMEOUT_EN` undefined:
  - WAIT exits only on done.
  - `timeout_i` is unused.
  - `err_o` and `err_mask_o` are tied to 0 and the timer is not synthesized.

## Structure
- Package `pixel_seq_pkg` holds:
  - the state enum (IDLE/SCAN/START/WAIT/DONE);
  - default `NPIX` / `TO_W` constants;
  - the `IDX_W` helper function.
- Sub-module `pixel_seq_timer`: a loadable, saturating timeout counter with a `clear` input and an `expired` output, instantiated only under `PIXEL_SEQ_TIMEOUT_EN`.

## Test plan
- NPIX=9, mask=0x1FF, timeout=0, each done returned 3 cycles after its start → starts issued for idx 0..8 in order, one `done_o` pulse, `err_mask_o` = 0.
- mask=0x105 → starts only on pixels 0, 2, 8; `pxl_start_o` never shows bits 1, 3–7.
- timeout=5, pixel 4 never done, all others done immediately → `err_mask_o` = 0x010, `err_o` = 1, scan completes, and pixel 5 starts 2 cycles after the timeout.
- timeout=4, done for the active pixel arrives exactly on the expiry cycle → no error bit set.
- mask=0 → `done_o` pulses NPIX+2 cycles after `start_i`, with no starts issued.
- `rst` asserted during WAIT on pixel 3, then `start_i` reasserted → clean restart from pixel 0, with errors from before the reset cleared.
